// File: rtl/voq_fifo.sv
// Multi-channel packet queue: NCH virtual output queues sharing one write and one read port,
// with per-channel occupancy, almost-full, flush and sticky overflow/underflow flags.
module voq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int NCH   = 4,
    parameter int AF    = DEPTH - 2,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          in,
    input  logic                  we,
    input  logic [CW-1:0]         wch,
    output logic [W-1:0]          out,
    input  logic                  re,
    input  logic [CW-1:0]         rch,
    input  logic [NCH-1:0]        flush,
    input  logic                  clr_err,
    output logic [NCH-1:0]        empty,
    output logic [NCH-1:0]        full,
    output logic [NCH-1:0]        afull,
    output logic [NCH*(AW+1)-1:0] count,
    output logic                  ovf,
    output logic                  udf
);

    logic [AW-1:0]  head_q [NCH];
    logic [AW-1:0]  head_d [NCH];
    logic [AW-1:0]  tail_q [NCH];
    logic [AW-1:0]  tail_d [NCH];
    logic [AW:0]    cnt_q  [NCH];
    logic [AW:0]    cnt_d  [NCH];
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;
    logic [W-1:0]   mem_q  [NCH*DEPTH];

    logic           wch_ok, rch_ok;
    logic [NCH-1:0] wr_hit, rd_hit, wr_acc, rd_acc;
    logic           ovf_set, udf_set, wr_en;

    // Indices beyond NCH only exist when NCH is not a power of two; they address nothing.
    assign wch_ok = ({1'b0, wch} < (CW+1)'(NCH));
    assign rch_ok = ({1'b0, rch} < (CW+1)'(NCH));

    always_comb begin
        empty = '0;
        full  = '0;
        afull = '0;
        count = '0;
        for (int i = 0; i < NCH; i++) begin
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == (AW+1)'(DEPTH));
            afull[i] = (cnt_q[i] >= (AW+1)'(AF));
            count[i*(AW+1) +: AW+1] = cnt_q[i];
        end
    end

    always_comb begin
        wr_hit  = '0;
        rd_hit  = '0;
        wr_acc  = '0;
        rd_acc  = '0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            cnt_d[i]  = cnt_q[i];
            wr_hit[i] = we && wch_ok && (wch == CW'(i));
            rd_hit[i] = re && rch_ok && (rch == CW'(i));
            // Flush discards any same-cycle access to the channel without raising errors.
            if (flush[i]) begin
                head_d[i] = '0;
                tail_d[i] = '0;
                cnt_d[i]  = '0;
            end else begin
                wr_acc[i] = wr_hit[i] && !full[i];
                rd_acc[i] = rd_hit[i] && !empty[i];
                if (wr_hit[i] && full[i])  ovf_set = 1'b1;
                if (rd_hit[i] && empty[i]) udf_set = 1'b1;
                if (wr_acc[i]) head_d[i] = head_q[i] + 1'b1;
                if (rd_acc[i]) tail_d[i] = tail_q[i] + 1'b1;
                case ({wr_acc[i], rd_acc[i]})
                    2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                    2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                    default: cnt_d[i] = cnt_q[i];
                endcase
            end
        end
        wr_en = |wr_acc;
        ovf_d = (ovf_q && !clr_err) || ovf_set;
        udf_d = (udf_q && !clr_err) || udf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Storage is never reset; pointers and counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[{wch, head_q[wch]}] <= in;
    end

    assign out = (rch_ok && !empty[rch]) ? mem_q[{rch, tail_q[rch]}] : '0;
    assign ovf = ovf_q;
    assign udf = udf_q;

endmodule

// File: doc/voq_fifo.md
# voq_fifo

Multi-channel packet queue for the switch ports: NCH independent FIFO queues (virtual output queues) share one write port and one read port, each queue selected by a channel index. It generalises the single packet FIFO with parametrised width/depth/channel count, a full flag that uses every entry, per-channel occupancy counts, an almost-full threshold, per-channel flush and sticky overflow/underflow error flags. It sits between the input port parser (writer) and the output arbiter (reader).

## Interface
- W, 32, packet word width in bits
- DEPTH, 8, entries per channel; power of 2, >= 2
- NCH, 4, number of channels; >= 2
- AF, DEPTH-2, almost-full threshold in entries; 1..DEPTH
- Derived: CW = $clog2(NCH), AW = $clog2(DEPTH); counts are AW+1 bits wide
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in  in  W  write data
- we  in  1  write strobe
- wch  in  CW  write channel index
- out  out  W  head word of channel rch; 0 when that channel is empty
- re  in  1  read (pop) strobe
- rch  in  CW  read channel index
- flush  in  NCH  per-channel flush, one bit per channel
- clr_err  in  1  clears ovf/udf
- empty  out  NCH  channel i holds 0 entries
- full  out  NCH  channel i holds DEPTH entries
- afull  out  NCH  channel i count >= AF
- count  out  NCH*(AW+1)  packed occupancy; channel i in bits [i*(AW+1) +: AW+1]
- ovf  out  1  sticky: write attempted to a full channel
- udf  out  1  sticky: read attempted from an empty channel

## Operation
- Per channel: head pointer, tail pointer (AW bits, wrap modulo DEPTH), count (AW+1 bits). Storage: NCH*DEPTH words of W bits.
- empty[i] = (count_i == 0); full[i] = (count_i == DEPTH); afull[i] = (count_i >= AF). All derived from registered count.
- Write: we && !full[wch] && !flush[wch] -> mem[wch][head] <= in, head++, count++.
- Write to full channel (we && full[wch], no flush): dropped, state unchanged, ovf <= 1. Drop decision uses the registered full even when a read of the same channel occurs the same cycle.
- Read: re && !empty[rch] && !flush[rch] -> tail++, count--.
- Read of empty channel (re && empty[rch], no flush): no state change, udf <= 1. A same-cycle write to that channel is still accepted.
- Same-channel simultaneous accepted read and write: head++, tail++, count unchanged.
- Different channels: write and read proceed independently.
- flush[i]: head_i, tail_i, count_i <= 0; takes priority over any we/re targeting channel i that cycle; those operations are discarded without setting ovf/udf. Storage contents are not cleared.
- Error flags: set as above; clr_err clears both; a set event in the same cycle as clr_err wins (flag ends 1).
- out = empty[rch] ? 0 : mem[rch][tail_rch] (first-word-fall-through, combinational in rch).
- Out-of-range indices (wch/rch >= NCH when NCH is not a power of 2): write dropped, read ignored, out = 0, no error flag.

## Timing
- Reset (rst high at edge): all pointers and counts 0; empty = all 1; full = 0; afull = 0 (AF >= 1); ovf = udf = 0; out = 0. rst overrides we/re/flush/clr_err in the same cycle. Reset mid-operation discards all queued data.
- Write latency: word written at edge N is visible on out (if it is the channel head and rch selects it) and counted from after edge N, i.e. cycle N+1. No write-to-read bypass when the channel is empty.
- Read latency: 0; out is valid combinationally in the cycle re is asserted; the next word appears after the edge.
- Flags and count update one edge after the causing operation; sustained 1 write + 1 read per cycle.

## Test plan
- Reset then idle: empty=4'b1111, full=0, afull=0, all counts 0, out=0, ovf=udf=0.
- Fill channel 2 with 8 words 0x100..0x107: after the 6th write afull[2]=1, after the 8th full[2]=1, count ch2=8; 9th write (0xDEAD) dropped, ovf=1; drain with rch=2 returns 0x100..0x107 in order, then empty[2]=1.
- Full channel 1 with simultaneous we/re on channel 1: read pops the head, write dropped, ovf=1, count stays at DEPTH-1=7.
- Empty channel 0: re with we (0x55) same cycle -> udf=1, count ch0=1 next cycle, out=0x55 next cycle.
- Interleaved writes to channels 0 and 3 while reading channel 3; wrap pointers over 3*DEPTH words; per-channel order preserved, no cross-channel leakage.
- Channel 3 holding 5 words, flush[3] with we/re to channel 3 same cycle -> count ch3=0, empty[3]=1, ovf/udf unchanged; clr_err clears previously set flags.
